int_ctrl_n: RTL and testbench

- Parametrised N-source machine-mode interrupt controller for the tinyriscv core; successor to the single fixed timer-0 interrupt path.
- Latches edge-triggered requests from NUM_SRC peripherals, applies per-source and global enables, and arbitrates by fixed priority.
- Holds the pipeline while it sequences the trap CSR writes (mepc, mcause, mstatus), then asserts a jump to the vector.
- On mret it restores mstatus and jumps back to the saved mepc.

---
 rtl/int_ctrl_n_if.sv | 23 ++
 rtl/int_ctrl_n.sv | 168 ++++++++++++++++
 tb/tb_int_ctrl_n.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_n_if.sv
// Core-side bus of the interrupt controller: pipeline hold, CSR write port
// and the jump request. The controller drives it (master), the core samples it (slave).
interface int_ctrl_n_if #(
  parameter int INT_ID_W = 8
);
  logic                hold_flag_o;
  logic                csr_we_o;
  logic [11:0]         csr_waddr_o;
  logic [31:0]         csr_wdata_o;
  logic                int_assert_o;
  logic [31:0]         int_addr_o;
  logic [INT_ID_W-1:0] int_id_o;

  modport master (
    output hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o,
           int_assert_o, int_addr_o, int_id_o
  );

  modport slave (
    input hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o,
          int_assert_o, int_addr_o, int_id_o
  );
endinterface

// File: rtl/int_ctrl_n.sv
// N-source machine-mode interrupt controller for tinyriscv.
// Latches request edges, arbitrates lowest-index-first, sequences the trap
// CSR writes (mepc, mcause, mstatus), jumps to the vector, and on mret
// restores mstatus and jumps back to mepc.
// Optional build macro: INT_CTRL_VECTORED_EN selects vectored jump targets
// (VEC_BASE + id*VEC_STRIDE); without it every source jumps to VEC_BASE.

// Per-source pending cell: edge detector plus sticky pending flag.
module int_ctrl_n_src (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic irq_q;

  // a fresh rising edge wins over a same-cycle clear so no request is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q <= 1'b0;
      pend  <= 1'b0;
    end else begin
      irq_q <= irq;
      if (irq && !irq_q) pend <= 1'b1;
      else if (clr)      pend <= 1'b0;
    end
  end
endmodule

module int_ctrl_n #(
  parameter int          NUM_SRC    = 8,
  parameter int          INT_ID_W   = 8,
  parameter logic [31:0] VEC_BASE   = 32'h4,
  parameter int          VEC_STRIDE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic [NUM_SRC-1:0] int_en_i,
  input  logic [31:0]        mstatus_i,
  input  logic [31:0]        inst_addr_i,
  input  logic               mret_i,
  int_ctrl_n_if.master       bus
);
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  typedef enum logic [2:0] {
    S_IDLE, S_MEPC, S_MCAUSE, S_MSTATUS,
    S_ASSERT, S_IN_HANDLER, S_RET_STATUS, S_RET_ASSERT
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         mepc_q;
  logic [INT_ID_W-1:0] id_q;
  logic [INT_ID_W-1:0] win;
  logic [NUM_SRC-1:0]  pend, clr, cand;
  logic                take;
  logic [31:0]         vec_addr;

  int_ctrl_n_src u_src [NUM_SRC-1:0] (
    .clk  (clk),
    .rst  (rst),
    .irq  (irq_i),
    .clr  (clr),
    .pend (pend)
  );

  assign cand = pend & int_en_i;
  assign take = (state_q == S_IDLE) && mstatus_i[3] && (|cand);

  // fixed priority: scan downwards so the lowest set index is left in win
  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (cand[i]) win = INT_ID_W'(i);
  end

  // only the taken source is acknowledged, and only in the jump cycle
  always_comb begin
    clr = '0;
    if (state_q == S_ASSERT)
      for (int i = 0; i < NUM_SRC; i++)
        clr[i] = (id_q == INT_ID_W'(i));
  end

`ifdef INT_CTRL_VECTORED_EN
  assign vec_addr = VEC_BASE + 32'(id_q) * 32'(VEC_STRIDE);
`else
  assign vec_addr = VEC_BASE;
`endif

  // state register; mepc/id are captured together with the take decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mepc_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        mepc_q <= inst_addr_i;
        id_q   <= win;
      end
    end
  end

  logic                hold, we, jmp;
  logic [11:0]         waddr;
  logic [31:0]         wdata, jaddr;
  logic [INT_ID_W-1:0] jid;

  // next state and outputs; everything idles at zero outside its own state
  always_comb begin
    state_d = state_q;
    hold    = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    jmp     = 1'b0;
    jaddr   = '0;
    jid     = '0;
    case (state_q)
      S_IDLE: if (take) state_d = S_MEPC;
      S_MEPC: begin
        hold = 1'b1; we = 1'b1; waddr = CSR_MEPC; wdata = mepc_q;
        state_d = S_MCAUSE;
      end
      S_MCAUSE: begin
        hold = 1'b1; we = 1'b1; waddr = CSR_MCAUSE;
        wdata = {1'b1, 31'(id_q + 1'b1)};
        state_d = S_MSTATUS;
      end
      S_MSTATUS: begin
        // MPIE <- MIE, MIE <- 0
        hold = 1'b1; we = 1'b1; waddr = CSR_MSTATUS;
        wdata = {mstatus_i[31:8], mstatus_i[3], mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
        state_d = S_ASSERT;
      end
      S_ASSERT: begin
        hold = 1'b1; jmp = 1'b1; jaddr = vec_addr; jid = id_q + 1'b1;
        state_d = S_IN_HANDLER;
      end
      S_IN_HANDLER: if (mret_i) state_d = S_RET_STATUS;
      S_RET_STATUS: begin
        // MIE <- MPIE, MPIE <- 1
        hold = 1'b1; we = 1'b1; waddr = CSR_MSTATUS;
        wdata = {mstatus_i[31:8], 1'b1, mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};
        state_d = S_RET_ASSERT;
      end
      S_RET_ASSERT: begin
        hold = 1'b1; jmp = 1'b1; jaddr = mepc_q; jid = INT_ID_W'(8'hff);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.hold_flag_o  = hold;
  assign bus.csr_we_o     = we;
  assign bus.csr_waddr_o  = waddr;
  assign bus.csr_wdata_o  = wdata;
  assign bus.int_assert_o = jmp;
  assign bus.int_addr_o   = jaddr;
  assign bus.int_id_o     = jid;
endmodule

// File: tb/tb_int_ctrl_n.sv
// Bench for int_ctrl_n: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a queue-of-expected-outputs model.
module tb_int_ctrl_n;
  localparam int NS = 8;

  logic          clk, rst;
  logic [NS-1:0] irq, en;
  logic [31:0]   ms, inst;
  logic          mret;

  int_ctrl_n_if #(.INT_ID_W(8)) bus ();

  int_ctrl_n #(.NUM_SRC(NS), .INT_ID_W(8), .VEC_BASE(32'h4), .VEC_STRIDE(4)) dut (
    .clk(clk), .rst(rst), .irq_i(irq), .int_en_i(en), .mstatus_i(ms),
    .inst_addr_i(inst), .mret_i(mret), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // model: what the controller is showing now, and what it will show next
  localparam int K_IDLE = 0, K_MEPC = 1, K_MCAUSE = 2, K_MSTAT = 3,
                 K_ASSERT = 4, K_HAND = 5, K_RETS = 6, K_RETA = 7;
  logic [NS-1:0] m_pend, m_prev;
  int            m_q[$];
  int            m_cur;
  logic [31:0]   m_mepc;
  int            m_id;
  logic [86:0]   exp_out;

  function automatic logic [31:0] vec(int i);
`ifdef INT_CTRL_VECTORED_EN
    return 32'(4 + i * 4);
`else
    return 32'h4 + 32'(i * 0);
`endif
  endfunction

  function automatic logic [86:0] model_out(int cur, logic [31:0] m);
    logic h, we, as;
    logic [11:0] wa;
    logic [31:0] wd, ia;
    logic [7:0] id;
    h = (cur != K_IDLE) && (cur != K_HAND);
    we = 0; as = 0; wa = 0; wd = 0; ia = 0; id = 0;
    case (cur)
      K_MEPC:   begin we = 1; wa = 12'h341; wd = m_mepc; end
      K_MCAUSE: begin we = 1; wa = 12'h342; wd = 32'h8000_0000 | 32'(m_id + 1); end
      K_MSTAT:  begin we = 1; wa = 12'h300; wd = (m & ~32'h88) | (m[3] ? 32'h80 : 32'h0); end
      K_ASSERT: begin as = 1; ia = vec(m_id); id = 8'(m_id + 1); end
      K_RETS:   begin we = 1; wa = 12'h300; wd = (m & ~32'h88) | 32'h80 | (m[7] ? 32'h8 : 32'h0); end
      K_RETA:   begin as = 1; ia = m_mepc; id = 8'hff; end
      default:  ;
    endcase
    return {h, we, wa, wd, as, ia, id};
  endfunction

  function automatic logic [86:0] obs();
    return {bus.hold_flag_o, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o,
            bus.int_assert_o, bus.int_addr_o, bus.int_id_o};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_q.delete(); m_cur = K_IDLE; m_mepc = '0; m_id = 0;
  endtask

  // advance one clock: update the model from the inputs about to be sampled,
  // then land 1 time unit after the edge with the new expectation ready
  task automatic step();
    logic [NS-1:0] cand;
    int w;
    cand = m_pend & en;
    if (m_cur == K_IDLE && ms[3] && cand != 0) begin
      w = 0;
      for (int i = NS - 1; i >= 0; i--) if (cand[i]) w = i;
      m_id = w; m_mepc = inst;
      m_q = '{K_MEPC, K_MCAUSE, K_MSTAT, K_ASSERT, K_HAND};
    end else if (m_cur == K_HAND && mret) begin
      m_q = '{K_RETS, K_RETA, K_IDLE};
    end
    if (m_cur == K_ASSERT) m_pend[m_id] = 1'b0;
    m_pend = m_pend | (irq & ~m_prev);
    m_prev = irq;
    if (m_q.size() != 0) m_cur = m_q.pop_front();
    @(posedge clk);
    #1;
    exp_out = model_out(m_cur, ms);
  endtask

  task automatic test_reset();
    rst = 0; irq = 0; en = 0; ms = 0; inst = 0; mret = 0;
    model_reset();
    #2;
    checks++;
    if (obs() !== 87'h0) begin errors++; $display("FAIL reset_async: got %h want 0", obs()); end
    @(posedge clk); #1;
    checks++;
    if (obs() !== 87'h0) begin errors++; $display("FAIL reset_held: got %h want 0", obs()); end
    rst = 1;
    step();
    checks++;
    if (obs() !== exp_out) begin errors++; $display("FAIL reset_release: got %h want %h", obs(), exp_out); end
  endtask

  task automatic test_basic_take();
    logic [11:0] wa[8];
    logic [31:0] wd[8];
    logic [31:0] aa;
    logic [7:0]  ai;
    int nw, na;
    nw = 0; na = 0; aa = 0; ai = 0;
    en = 8'hff; ms = 32'h8; inst = 32'h100; irq = 8'h01;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) irq = 0;
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL basic_cycle%0d: got %h want %h", k, obs(), exp_out); end
      if (bus.csr_we_o && nw < 8) begin wa[nw] = bus.csr_waddr_o; wd[nw] = bus.csr_wdata_o; nw++; end
      if (bus.int_assert_o) begin aa = bus.int_addr_o; ai = bus.int_id_o; na++; end
    end
    checks++;
    if (nw !== 3 || na !== 1) begin errors++; $display("FAIL basic_counts: got writes=%0d jumps=%0d want 3/1", nw, na); end
    else begin
      checks++;
      if ({wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]} !==
          {12'h341, 32'h100, 12'h342, 32'h8000_0001, 12'h300, 32'h80}) begin
        errors++; $display("FAIL basic_csr_seq: got %h/%h %h/%h %h/%h", wa[0], wd[0], wa[1], wd[1], wa[2], wd[2]);
      end
      checks++;
      if ({aa, ai} !== {32'h4, 8'h01}) begin errors++; $display("FAIL basic_jump: got %h/%h want 4/01", aa, ai); end
    end
    for (int k = 0; k < 6; k++) begin
      mret = (m_cur == K_HAND);
      step();
      mret = 0;
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL basic_ret%0d: got %h want %h", k, obs(), exp_out); end
    end
  endtask

  task automatic test_priority();
    logic [7:0]  ids[$];
    logic [31:0] adr[$];
    en = 8'hff; ms = 32'h8; inst = 32'h300; irq = 8'h24;
    for (int k = 0; k < 30; k++) begin
      mret = (m_cur == K_HAND);
      step();
      mret = 0; irq = 0;
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL prio_cycle%0d: got %h want %h", k, obs(), exp_out); end
      if (bus.int_assert_o && bus.int_id_o != 8'hff) begin ids.push_back(bus.int_id_o); adr.push_back(bus.int_addr_o); end
    end
    checks++;
    if (ids.size() !== 2) begin errors++; $display("FAIL prio_takes: got %0d want 2", ids.size()); end
    else begin
      checks++;
      if ({ids[0], ids[1]} !== {8'd3, 8'd6}) begin errors++; $display("FAIL prio_order: got %0d,%0d want 3,6", ids[0], ids[1]); end
      checks++;
`ifdef INT_CTRL_VECTORED_EN
      if ({adr[0], adr[1]} !== {32'hC, 32'h18}) begin
`else
      if ({adr[0], adr[1]} !== {32'h4, 32'h4}) begin
`endif
        errors++; $display("FAIL prio_addr: got %h,%h", adr[0], adr[1]);
      end
    end
  endtask

  task automatic test_disabled_pending();
    bit saw, got;
    saw = 0; got = 0;
    en = 8'hf7; ms = 32'h8; irq = 8'h08;
    for (int k = 0; k < 10; k++) begin
      step();
      irq = 0;
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL dis_cycle%0d: got %h want %h", k, obs(), exp_out); end
      if (bus.int_assert_o) saw = 1;
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL dis_no_take: got take=%0d want 0", saw); end
    en = 8'hff;
    for (int k = 0; k < 14; k++) begin
      mret = (m_cur == K_HAND);
      step();
      mret = 0;
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL dis_en_cycle%0d: got %h want %h", k, obs(), exp_out); end
      if (bus.int_assert_o && bus.int_id_o == 8'd4) got = 1;
    end
    checks++;
    if (got !== 1'b1) begin errors++; $display("FAIL dis_retained: got take=%0d want 1", got); end
  endtask

  task automatic test_mret();
    int k;
    en = 8'hff; ms = 32'h8; inst = 32'h200; irq = 8'h10;
    k = 0;
    do begin
      step();
      irq = 0;
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL mret_pre%0d: got %h want %h", k, obs(), exp_out); end
      k++;
    end while (m_cur != K_HAND && k < 10);
    checks++;
    if (m_cur != K_HAND || bus.hold_flag_o !== 1'b0) begin
      errors++; $display("FAIL mret_handler_timeout: got hold=%b want 0 in handler", bus.hold_flag_o);
    end
    ms = 32'h80; mret = 1;
    step();
    mret = 0;
    checks++;
    if ({bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o} !== {1'b1, 12'h300, 32'h88}) begin
      errors++; $display("FAIL mret_status: got %b/%h/%h want 1/300/88", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o);
    end
    step();
    checks++;
    if ({bus.int_assert_o, bus.int_addr_o, bus.int_id_o} !== {1'b1, 32'h200, 8'hff}) begin
      errors++; $display("FAIL mret_jump: got %b/%h/%h want 1/200/ff", bus.int_assert_o, bus.int_addr_o, bus.int_id_o);
    end
    step();
    checks++;
    if (obs() !== exp_out || obs() !== 87'h0) begin errors++; $display("FAIL mret_idle: got %h want 0", obs()); end
    ms = 32'h8;
  endtask

  task automatic test_reset_mid();
    int k;
    en = 8'hff; ms = 32'h8; irq = 8'h42;
    k = 0;
    do begin
      step();
      irq = 0;
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL rmid_pre%0d: got %h want %h", k, obs(), exp_out); end
      k++;
    end while (m_cur != K_MCAUSE && k < 10);
    checks++;
    if (bus.csr_waddr_o !== 12'h342) begin errors++; $display("FAIL rmid_mcause_timeout: got %h want 342", bus.csr_waddr_o); end
    rst = 0;
    #1;
    checks++;
    if (obs() !== 87'h0) begin errors++; $display("FAIL rmid_outputs: got %h want 0", obs()); end
    model_reset();
    @(posedge clk); #1;
    rst = 1;
    for (int j = 0; j < 8; j++) begin
      mret = (j == 2);
      step();
      mret = 0;
      checks++;
      if (obs() !== 87'h0 || obs() !== exp_out) begin errors++; $display("FAIL rmid_after%0d: got %h want 0", j, obs()); end
    end
  endtask

  task automatic test_held_irq();
    int n, k;
    en = 8'hff; ms = 32'h8; irq = 8'h02;
    n = 0;
    for (int j = 0; j < 20; j++) begin
      mret = (m_cur == K_HAND);
      step();
      mret = 0;
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL held_cycle%0d: got %h want %h", j, obs(), exp_out); end
      if (bus.int_assert_o && bus.int_id_o == 8'd2) n++;
    end
    checks++;
    if (n !== 1) begin errors++; $display("FAIL held_one_take: got %0d want 1", n); end
    irq = 0; step(); irq = 8'h02; step(); irq = 0;
    k = 0;
    do begin
      step();
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL held_seq%0d: got %h want %h", k, obs(), exp_out); end
      k++;
    end while (m_cur != K_ASSERT && k < 10);
    checks++;
    if (bus.int_assert_o !== 1'b1) begin errors++; $display("FAIL held_assert_timeout: got %b want 1", bus.int_assert_o); end
    irq = 8'h02;
    n = 0;
    for (int j = 0; j < 20; j++) begin
      step();
      mret = 0;
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL held_repend%0d: got %h want %h", j, obs(), exp_out); end
      if (bus.int_assert_o && bus.int_id_o == 8'd2) n++;
      mret = (m_cur == K_HAND);
    end
    mret = 0;
    checks++;
    if (n !== 1) begin errors++; $display("FAIL held_repend_take: got %0d want 1", n); end
  endtask

  task automatic test_random();
    for (int j = 0; j < 600; j++) begin
      irq  = irq ^ NS'($urandom & $urandom & $urandom);
      en   = NS'($urandom | $urandom);
      ms   = $urandom;
      if ($urandom_range(3) != 0) ms[3] = 1'b1;
      inst = $urandom;
      mret = (m_cur == K_HAND) ? ($urandom_range(2) == 0) : ($urandom_range(9) == 0);
      step();
      checks++;
      if (obs() !== exp_out) begin errors++; $display("FAIL rand_cycle%0d: got %h want %h", j, obs(), exp_out); end
    end
    mret = 0;
  endtask

  initial begin
    test_reset();
    test_basic_take();
    test_priority();
    test_disabled_pending();
    test_mret();
    test_reset_mid();
    test_held_irq();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
